err_loc_stream_out: RTL and testbench
=====================================

Name: err_loc_stream_out

Overview:
- Parametrised error-location serializer at the decoder back end.
- Captures one candidate error set (up to MAX_ERR locations) from the selected candidate on a valid/ready input handshake.
- Streams the set out one location per accepted beat, with backpressure, last-beat marking and an abort/early-stop sentinel path.
- Successor of the fixed 6-location, 4-candidate output selector. Adds arbitrary width, depth and candidate count, output ready, and back-to-back bursts.

Parameters:
- LOC_W, 10, width of one error location; SENTINEL = all ones (1023 at default).
- MAX_ERR, 6, maximum locations per set in mode 1.
- NUM_CAND, 4, number of candidate sets presented in parallel.
- MODE0_MAX, 4, location cap in mode 0 (must be <= MAX_ERR).
- SEL_W, 2, width of candidate select (>= clog2(NUM_CAND)).
- CNT_W, 3, width of count fields (>= clog2(MAX_ERR+1)).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_mode  in  1  0: single source, candidate 0 only, cap MODE0_MAX; 1: select by i_sel, cap MAX_ERR
- i_in_valid  in  1  candidate sets and select valid
- o_in_ready  out  1  block can capture a set this cycle
- i_sel  in  SEL_W  candidate index (mode 1)
- i_cand_loc  in  NUM_CAND*MAX_ERR*LOC_W  candidate c, location k at bits [(c*MAX_ERR+k)*LOC_W +: LOC_W]
- i_cand_num  in  NUM_CAND*CNT_W  error count of candidate c at [c*CNT_W +: CNT_W]
- i_abort  in  1  early-stop pulse
- o_err_loc  out  LOC_W  current location or SENTINEL
- o_valid  out  1  o_err_loc valid
- o_last  out  1  final beat of the burst
- i_out_ready  in  1  downstream accepts the beat
- o_busy  out  1  burst or sentinel pending

Behaviour:
- Reset: state IDLE; o_valid=0, o_last=0, o_err_loc=SENTINEL, o_busy=0, o_in_ready=0 during reset; captured buffer and counters cleared.
- Capture occurs when i_in_valid && o_in_ready.
  - Registers all locations of the effective candidate, plus n.
  - Effective candidate: 0 in mode 0, i_sel in mode 1.
  - n = min(count, cap).
  - i_sel >= NUM_CAND (mode 1) is treated as n=0.
- States:
  - IDLE: o_valid=0. On capture, go to EMIT with index=0.
  - EMIT, n>=1: o_valid=1, o_err_loc=loc[index], o_last=(index==n-1).
  - EMIT, n==0: exactly one beat, o_err_loc=SENTINEL, o_valid=1, o_last=1.
  - SENT: single abort beat, SENTINEL, o_valid=1, o_last=1.
- Latency: first beat is visible the cycle after capture. All outputs are registered.
- Beat transfer occurs when o_valid && i_out_ready.
  - If o_last: return to IDLE, or start the next burst (see back-to-back).
  - Otherwise index+1.
  - Without i_out_ready, o_err_loc, o_last and o_valid hold stable.
- o_in_ready = !i_rst && !i_abort && (state==IDLE || (state==EMIT && o_valid && o_last && i_out_ready)).
- Back-to-back: capture coincident with the last-beat transfer loads the new set. Its first beat appears on the next cycle with zero bubble.
- Abort (i_abort=1, any state): takes precedence over capture and transfer.
  - Current burst is discarded; index is cleared.
  - Next cycle enters SENT.
  - i_abort while already in SENT: no extra beat, sentinel still held.
- Locations are emitted in ascending index order (loc0 first). No reordering or duplicate filtering.
- o_busy = (state != IDLE).
- Mid-operation reset returns everything to reset values on the next edge. No partial beat follows.
- Mode changes are sampled only at capture; the mode is held in a register for the burst.

Test Plan:
- Mode 1, i_sel=2, cand2 num=3, locs {17,300,1022}, i_out_ready=1 -> beats 17,300,1022 on cycles T+1..T+3; o_last only on 1022; o_in_ready high at T+3.
- Mode 0, cand0 num=6 locs {1..6}, MODE0_MAX=4 -> exactly beats 1,2,3,4, last on 4; i_sel ignored.
- num=0 capture -> single beat 1023 with o_last=1. Mode 1 i_sel=5 with SEL_W=3, NUM_CAND=4 -> same single 1023 beat.
- Backpressure: num=2 {5,9}, i_out_ready low 3 cycles after first beat -> o_err_loc stays 5 and o_valid stays 1, then 5,9 on release; no loss or duplicate.
- Back-to-back: second set {40} presented with i_in_valid during the last beat of {7,8} -> stream 7,8,40 contiguous; o_last on 8 and on 40.
- i_abort during beat 2 of a 5-error burst -> next cycle single 1023 with o_last, held until ready. Simultaneous i_in_valid is not captured. A second abort while pending gives no extra beat.

Source files
------------

// File: rtl/err_loc_stream_out_if.sv
// Purpose: bundles the candidate-capture handshake and the location output stream of err_loc_stream_out.
// Latency: none; this is wiring only.
// Backpressure: carries o_in_ready upstream and i_out_ready from downstream.
interface err_loc_stream_out_if #(
    parameter int LOC_W    = 10,
    parameter int MAX_ERR  = 6,
    parameter int NUM_CAND = 4,
    parameter int SEL_W    = 2,
    parameter int CNT_W    = 3
) ();
    // capture side
    logic                               i_mode;
    logic                               i_in_valid;
    logic                               o_in_ready;
    logic [SEL_W-1:0]                   i_sel;
    logic [NUM_CAND*MAX_ERR*LOC_W-1:0]  i_cand_loc;
    logic [NUM_CAND*CNT_W-1:0]          i_cand_num;
    logic                               i_abort;
    // stream side
    logic [LOC_W-1:0]                   o_err_loc;
    logic                               o_valid;
    logic                               o_last;
    logic                               i_out_ready;
    logic                               o_busy;

    // block view
    modport slave (
        input  i_mode, i_in_valid, i_sel, i_cand_loc, i_cand_num, i_abort, i_out_ready,
        output o_in_ready, o_err_loc, o_valid, o_last, o_busy
    );

    // driver / environment view
    modport master (
        output i_mode, i_in_valid, i_sel, i_cand_loc, i_cand_num, i_abort, i_out_ready,
        input  o_in_ready, o_err_loc, o_valid, o_last, o_busy
    );
endinterface

// File: rtl/err_loc_stream_out.sv
// Purpose: captures one candidate error-location set and streams it out one location per beat.
// Latency: first beat registered, visible the cycle after capture; back-to-back bursts have no bubble.
// Backpressure: beats hold while i_out_ready is low; capture only when idle or on the last-beat transfer.
module err_loc_stream_out #(
    parameter int LOC_W     = 10,
    parameter int MAX_ERR   = 6,
    parameter int NUM_CAND  = 4,
    parameter int MODE0_MAX = 4,
    parameter int SEL_W     = 2,
    parameter int CNT_W     = 3
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    err_loc_stream_out_if.slave  if_io
);

    localparam logic [LOC_W-1:0] SENTINEL = '1;
    localparam logic [CNT_W-1:0] CAP0     = CNT_W'(MODE0_MAX);
    localparam logic [CNT_W-1:0] CAP1     = CNT_W'(MAX_ERR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_SENT = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [LOC_W-1:0]   r_buf [MAX_ERR];
    logic [LOC_W-1:0]   w_buf_nxt [MAX_ERR];
    logic [CNT_W-1:0]   r_n, w_n_nxt;
    logic [CNT_W-1:0]   r_idx, w_idx_nxt;
    logic               r_valid, w_valid_nxt;
    logic               r_last, w_last_nxt;
    logic [LOC_W-1:0]   r_loc, w_loc_nxt;

    logic               w_sel_ok;
    logic [SEL_W-1:0]   w_sel_eff;
    logic [CNT_W-1:0]   w_cnt_raw;
    logic [CNT_W-1:0]   w_cap_lim;
    logic [CNT_W-1:0]   w_new_n;
    logic [LOC_W-1:0]   w_new_loc [MAX_ERR];
    logic [CNT_W-1:0]   w_idx_inc;
    logic               w_xfer;
    logic               w_in_ready;
    logic               w_cap;

    // Pick the effective candidate and clamp its count; an out-of-range select yields an empty set.
    // The mode only matters at this point, so its effect is fully held in r_n for the burst.
    always_comb begin
        w_sel_ok  = !if_io.i_mode || (int'(if_io.i_sel) < NUM_CAND);
        w_sel_eff = (if_io.i_mode && w_sel_ok) ? if_io.i_sel : '0;
        w_cnt_raw = if_io.i_cand_num[int'(w_sel_eff)*CNT_W +: CNT_W];
        w_cap_lim = if_io.i_mode ? CAP1 : CAP0;
        if (!w_sel_ok) begin
            w_new_n = '0;
        end else if (w_cnt_raw > w_cap_lim) begin
            w_new_n = w_cap_lim;
        end else begin
            w_new_n = w_cnt_raw;
        end
        for (int k = 0; k < MAX_ERR; k++) begin
            w_new_loc[k] = if_io.i_cand_loc[(int'(w_sel_eff)*MAX_ERR + k)*LOC_W +: LOC_W];
        end
    end

    assign w_xfer     = r_valid && if_io.i_out_ready;
    assign w_in_ready = !i_rst && !if_io.i_abort &&
                        ((r_state == S_IDLE) ||
                         (r_state == S_EMIT && r_valid && r_last && if_io.i_out_ready));
    assign w_cap      = if_io.i_in_valid && w_in_ready;
    assign w_idx_inc  = r_idx + CNT_W'(1);

    // Next state and next registered outputs; abort outranks capture, capture outranks plain transfer.
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_loc_nxt   = r_loc;
        for (int k = 0; k < MAX_ERR; k++) begin
            w_buf_nxt[k] = r_buf[k];
        end

        if (if_io.i_abort) begin
            // Drop the burst; the sentinel beat is (re)asserted and held until it is taken.
            w_state_nxt = S_SENT;
            w_idx_nxt   = '0;
            w_n_nxt     = '0;
            w_valid_nxt = 1'b1;
            w_last_nxt  = 1'b1;
            w_loc_nxt   = SENTINEL;
        end else if (w_cap) begin
            // Covers both a capture from idle and one coincident with the last-beat transfer.
            w_state_nxt = S_EMIT;
            w_idx_nxt   = '0;
            w_n_nxt     = w_new_n;
            for (int k = 0; k < MAX_ERR; k++) begin
                w_buf_nxt[k] = w_new_loc[k];
            end
            w_valid_nxt = 1'b1;
            if (w_new_n == '0) begin
                w_loc_nxt  = SENTINEL;
                w_last_nxt = 1'b1;
            end else begin
                w_loc_nxt  = w_new_loc[0];
                w_last_nxt = (w_new_n == CNT_W'(1));
            end
        end else if (w_xfer) begin
            if (r_last) begin
                w_state_nxt = S_IDLE;
                w_idx_nxt   = '0;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
                w_loc_nxt   = SENTINEL;
            end else begin
                w_idx_nxt  = w_idx_inc;
                w_last_nxt = (w_idx_inc == (r_n - CNT_W'(1)));
                w_loc_nxt  = SENTINEL;
                for (int k = 0; k < MAX_ERR; k++) begin
                    if (CNT_W'(k) == w_idx_inc) begin
                        w_loc_nxt = r_buf[k];
                    end
                end
            end
        end
    end

    // State, captured set and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_n     <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_loc   <= SENTINEL;
            for (int k = 0; k < MAX_ERR; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            r_state <= w_state_nxt;
            r_n     <= w_n_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_loc   <= w_loc_nxt;
            for (int k = 0; k < MAX_ERR; k++) begin
                r_buf[k] <= w_buf_nxt[k];
            end
        end
    end

    assign if_io.o_in_ready = w_in_ready;
    assign if_io.o_err_loc  = r_loc;
    assign if_io.o_valid    = r_valid;
    assign if_io.o_last     = r_last;
    assign if_io.o_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_err_loc_stream_out.sv
// Purpose: drives directed and random capture/stream traffic into err_loc_stream_out against a beat-queue model.
// Latency: expects each captured burst to appear one cycle after capture.
// Backpressure: toggles i_out_ready and checks that beats are held, not lost or repeated.
module tb_err_loc_stream_out;
    localparam int LOC_W     = 10;
    localparam int MAX_ERR   = 6;
    localparam int NUM_CAND  = 4;
    localparam int MODE0_MAX = 4;
    localparam int SEL_W     = 3;
    localparam int CNT_W     = 3;
    localparam logic [LOC_W-1:0] SENT = '1;

    typedef struct {
        logic [LOC_W-1:0] loc;
        logic             last;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    err_loc_stream_out_if #(.LOC_W(LOC_W), .MAX_ERR(MAX_ERR), .NUM_CAND(NUM_CAND),
                            .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

    err_loc_stream_out #(.LOC_W(LOC_W), .MAX_ERR(MAX_ERR), .NUM_CAND(NUM_CAND),
                         .MODE0_MAX(MODE0_MAX), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .if_io (bus)
    );

    int               checks = 0;
    int               errors = 0;
    logic [LOC_W-1:0] loc_a [NUM_CAND][MAX_ERR];
    logic [CNT_W-1:0] num_a [NUM_CAND];
    beat_t            q[$];      // beats still owed downstream, head is the one on the wire
    bit               m_sent;    // head of q is an abort sentinel
    int               got[$];    // locations the DUT handed over
    int               e[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_got(input string tag, input int exp_q[$]);
        chk({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk({tag, "_beat"}, got[i], exp_q[i]);
        end
        got.delete();
    endtask

    task automatic apply_cand();
        for (int c = 0; c < NUM_CAND; c++) begin
            bus.i_cand_num[c*CNT_W +: CNT_W] = num_a[c];
            for (int k = 0; k < MAX_ERR; k++) begin
                bus.i_cand_loc[(c*MAX_ERR+k)*LOC_W +: LOC_W] = loc_a[c][k];
            end
        end
    endtask

    // The burst a capture with the present inputs should produce.
    task automatic make_burst(output beat_t nb[$]);
        bit ok;
        int eff, cap, n;
        nb.delete();
        ok  = !(bus.i_mode && int'(bus.i_sel) >= NUM_CAND);
        eff = bus.i_mode ? int'(bus.i_sel) : 0;
        cap = bus.i_mode ? MAX_ERR : MODE0_MAX;
        n   = ok ? ((int'(num_a[eff]) < cap) ? int'(num_a[eff]) : cap) : 0;
        if (n == 0) begin
            nb.push_back('{SENT, 1'b1});
        end else begin
            for (int k = 0; k < n; k++) begin
                nb.push_back('{loc_a[eff][k], (k == n-1)});
            end
        end
    endtask

    // One clock: check ready before the edge, advance the model, check outputs after the edge.
    task automatic cyc();
        bit    exp_rdy, do_cap, rst_s, abort_s, ordy_s;
        beat_t nb[$];
        apply_cand();
        #1;
        exp_rdy = !rst && !bus.i_abort &&
                  (q.size() == 0 || (q.size() == 1 && !m_sent && bus.i_out_ready));
        chk("in_ready", bus.o_in_ready, exp_rdy);
        if (bus.o_valid && bus.i_out_ready) got.push_back(int'(bus.o_err_loc));
        do_cap  = bus.i_in_valid && exp_rdy;
        rst_s   = rst;
        abort_s = bus.i_abort;
        ordy_s  = bus.i_out_ready;
        make_burst(nb);
        @(posedge clk);
        if (rst_s) begin
            q.delete();
            m_sent = 1'b0;
        end else if (abort_s) begin
            q.delete();
            q.push_back('{SENT, 1'b1});
            m_sent = 1'b1;
        end else begin
            if (q.size() > 0 && ordy_s) begin
                void'(q.pop_front());
                if (q.size() == 0) m_sent = 1'b0;
            end
            if (do_cap) begin
                q = nb;
                m_sent = 1'b0;
            end
        end
        #1;
        chk("valid", bus.o_valid, q.size() != 0);
        chk("busy", bus.o_busy, q.size() != 0);
        if (q.size() != 0) begin
            chk("loc", bus.o_err_loc, q[0].loc);
            chk("last", bus.o_last, q[0].last);
        end else begin
            chk("last_idle", bus.o_last, 1'b0);
        end
        if (rst_s) chk("rst_loc", bus.o_err_loc, SENT);
    endtask

    initial begin
        rst             = 1'b1;
        bus.i_mode      = 1'b0;
        bus.i_in_valid  = 1'b0;
        bus.i_sel       = '0;
        bus.i_abort     = 1'b0;
        bus.i_out_ready = 1'b1;
        m_sent          = 1'b0;
        for (int c = 0; c < NUM_CAND; c++) begin
            num_a[c] = '0;
            for (int k = 0; k < MAX_ERR; k++) loc_a[c][k] = '0;
        end
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        got.delete();

        // mode 1, candidate 2, three locations
        bus.i_mode = 1'b1; bus.i_sel = 3'd2;
        num_a[2] = 3'd3; loc_a[2][0] = 10'd17; loc_a[2][1] = 10'd300; loc_a[2][2] = 10'd1022;
        bus.i_in_valid = 1'b1; cyc();
        bus.i_in_valid = 1'b0; repeat (4) cyc();
        e = '{17, 300, 1022}; chk_got("sel2", e);

        // mode 0 caps at MODE0_MAX and ignores i_sel
        bus.i_mode = 1'b0; bus.i_sel = 3'd2; num_a[0] = 3'd6;
        for (int k = 0; k < MAX_ERR; k++) loc_a[0][k] = LOC_W'(k + 1);
        bus.i_in_valid = 1'b1; cyc();
        bus.i_in_valid = 1'b0; repeat (6) cyc();
        e = '{1, 2, 3, 4}; chk_got("mode0cap", e);

        // empty set, then out-of-range select
        num_a[0] = 3'd0;
        bus.i_in_valid = 1'b1; cyc();
        bus.i_in_valid = 1'b0; repeat (2) cyc();
        e = '{1023}; chk_got("num0", e);
        bus.i_mode = 1'b1; bus.i_sel = 3'd5;
        bus.i_in_valid = 1'b1; cyc();
        bus.i_in_valid = 1'b0; repeat (2) cyc();
        e = '{1023}; chk_got("badsel", e);

        // backpressure holds the first beat
        bus.i_mode = 1'b0; num_a[0] = 3'd2; loc_a[0][0] = 10'd5; loc_a[0][1] = 10'd9;
        bus.i_in_valid = 1'b1; cyc();
        bus.i_in_valid = 1'b0; bus.i_out_ready = 1'b0; repeat (3) cyc();
        bus.i_out_ready = 1'b1; repeat (3) cyc();
        e = '{5, 9}; chk_got("bp", e);

        // back-to-back capture on the last beat
        bus.i_mode = 1'b1; bus.i_sel = 3'd1; num_a[1] = 3'd2; loc_a[1][0] = 10'd7; loc_a[1][1] = 10'd8;
        bus.i_in_valid = 1'b1; cyc();
        bus.i_in_valid = 1'b0; cyc();
        num_a[1] = 3'd1; loc_a[1][0] = 10'd40;
        bus.i_in_valid = 1'b1; cyc();
        bus.i_in_valid = 1'b0; repeat (3) cyc();
        e = '{7, 8, 40}; chk_got("b2b", e);

        // abort on beat 2 with a competing capture, then a second abort while pending
        bus.i_sel = 3'd3; num_a[3] = 3'd5;
        for (int k = 0; k < 5; k++) loc_a[3][k] = LOC_W'(100 + k);
        bus.i_in_valid = 1'b1; cyc();
        bus.i_in_valid = 1'b0; cyc();
        bus.i_abort = 1'b1; bus.i_in_valid = 1'b1; bus.i_out_ready = 1'b0; cyc();
        bus.i_abort = 1'b0; bus.i_in_valid = 1'b0; repeat (2) cyc();
        bus.i_abort = 1'b1; cyc();
        bus.i_abort = 1'b0; bus.i_out_ready = 1'b1; repeat (3) cyc();
        e = '{100, 1023}; chk_got("abort", e);

        // random traffic including mid-burst reset and abort
        for (int t = 0; t < 2000; t++) begin
            rst             = ($urandom_range(99) < 1);
            bus.i_abort     = ($urandom_range(99) < 3);
            bus.i_in_valid  = ($urandom_range(99) < 40);
            bus.i_out_ready = ($urandom_range(99) < 70);
            bus.i_mode      = ($urandom_range(1) == 1);
            bus.i_sel       = SEL_W'($urandom_range(7));
            for (int c = 0; c < NUM_CAND; c++) begin
                num_a[c] = CNT_W'($urandom_range(7));
                for (int k = 0; k < MAX_ERR; k++) loc_a[c][k] = LOC_W'($urandom);
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
